// File: rtl/dsmod_decim_multich_if.sv
// Host-side bundle of the multi-channel delta-sigma decimator: modulator
// bitstream, run-time configuration, start/stop control and result handshake.
interface dsmod_decim_multich_if #(
    parameter int NCH   = 2,
    parameter int OSR_W = 10,
    parameter int OUT_W = 16
);
    logic                   sample_en;
    logic [NCH-1:0]         dsmod_bit_in;
    logic [OSR_W-1:0]       osr_in;
    logic                   sinc2_en;
    logic                   continuous_en;
    logic [NCH-1:0]         ch_enable_in;
    logic                   start_conversion_in;
    logic                   stop_in;
    logic [NCH*OUT_W-1:0]   result_out;
    logic                   result_valid_out;
    logic                   result_ack_in;
    logic                   busy_out;
    logic                   conversion_finished_out;
    logic                   overrun_out;

    // Decimator side
    modport slave (
        input  sample_en, dsmod_bit_in, osr_in, sinc2_en, continuous_en,
               ch_enable_in, start_conversion_in, stop_in, result_ack_in,
        output result_out, result_valid_out, busy_out,
               conversion_finished_out, overrun_out
    );

    // Host side
    modport master (
        output sample_en, dsmod_bit_in, osr_in, sinc2_en, continuous_en,
               ch_enable_in, start_conversion_in, stop_in, result_ack_in,
        input  result_out, result_valid_out, busy_out,
               conversion_finished_out, overrun_out
    );
endinterface

// File: rtl/dsmod_decim_multich.sv
// Multi-channel sinc1/sinc2 decimator with start/stop control, single-shot or
// continuous operation and a valid/ack result port with sticky overrun.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; last result and valid flag are held
// S_RUN  | consuming strobed modulator bits, emitting a result per window
//
// sinc2 is evaluated without a multiplier: within a frame each bit at position
// j is accumulated with weight j+1 (its weight when the frame is the older half
// of the window) and with weight OSR-1-j (its weight as the newer half). The
// result is the previous frame's "older" sum plus the current frame's "newer"
// sum, which slides cleanly by one frame in continuous mode.
module dsmod_decim_multich #(
    parameter int NCH   = 2,
    parameter int OSR_W = 10,
    parameter int OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dsmod_decim_multich_if.slave dsm
);
    localparam int RAW_W = 2*OSR_W + 1;
    localparam int CW    = (RAW_W > OUT_W) ? RAW_W : OUT_W;
    localparam logic [CW-1:0] SAT_MAX = CW'({OUT_W{1'b1}});

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               r_state;
    logic [OSR_W-1:0]     r_osr;
    logic [OSR_W-1:0]     r_cnt;
    logic                 r_sinc2;
    logic                 r_cont;
    logic [NCH-1:0]       r_chen;
    logic                 r_have_prev;
    logic [RAW_W-1:0]     r_s  [NCH];
    logic [RAW_W-1:0]     r_w  [NCH];
    logic [RAW_W-1:0]     r_v  [NCH];
    logic [RAW_W-1:0]     r_pw [NCH];
    logic [NCH*OUT_W-1:0] r_result;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ovr;

    logic [RAW_W-1:0]     w_s_nx [NCH];
    logic [RAW_W-1:0]     w_w_nx [NCH];
    logic [RAW_W-1:0]     w_v_nx [NCH];
    logic [RAW_W-1:0]     w_wt_up;
    logic [RAW_W-1:0]     w_wt_dn;
    logic [NCH*OUT_W-1:0] w_result;
    logic [OSR_W-1:0]     w_osr_eff;
    logic                 w_frame_end;
    logic                 w_res_rdy;

    function automatic logic [OUT_W-1:0] f_sat(input logic [RAW_W-1:0] raw);
        logic [CW-1:0] ext;
        ext = CW'(raw);
        if (ext > SAT_MAX) return OUT_W'(SAT_MAX);
        return OUT_W'(ext);
    endfunction

    assign w_osr_eff   = (dsm.osr_in < OSR_W'(2)) ? OSR_W'(2) : dsm.osr_in;
    assign w_frame_end = (r_cnt == (r_osr - OSR_W'(1)));
    assign w_res_rdy   = w_frame_end && (!r_sinc2 || r_have_prev);

    // Next accumulator values including the current bit, and the saturated result
    always_comb begin
        w_wt_up  = RAW_W'(r_cnt) + RAW_W'(1);
        w_wt_dn  = RAW_W'(r_osr) - RAW_W'(r_cnt) - RAW_W'(1);
        w_result = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            w_s_nx[ch] = r_s[ch] + RAW_W'(dsm.dsmod_bit_in[ch]);
            w_w_nx[ch] = r_w[ch] + (dsm.dsmod_bit_in[ch] ? w_wt_up : '0);
            w_v_nx[ch] = r_v[ch] + (dsm.dsmod_bit_in[ch] ? w_wt_dn : '0);
            if (r_chen[ch]) begin
                w_result[ch*OUT_W +: OUT_W] = r_sinc2 ? f_sat(r_pw[ch] + w_v_nx[ch])
                                                     : f_sat(w_s_nx[ch]);
            end
        end
    end

    // Control FSM, filter state and registered host outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_osr       <= OSR_W'(2);
            r_cnt       <= '0;
            r_sinc2     <= 1'b0;
            r_cont      <= 1'b0;
            r_chen      <= '0;
            r_have_prev <= 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_s[ch]  <= '0;
                r_w[ch]  <= '0;
                r_v[ch]  <= '0;
                r_pw[ch] <= '0;
            end
            r_result    <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (dsm.result_ack_in) r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dsm.start_conversion_in && !dsm.stop_in) begin
                        r_osr       <= w_osr_eff;
                        r_sinc2     <= dsm.sinc2_en;
                        r_cont      <= dsm.continuous_en;
                        r_chen      <= dsm.ch_enable_in;
                        r_cnt       <= '0;
                        r_have_prev <= 1'b0;
                        for (int ch = 0; ch < NCH; ch++) begin
                            r_s[ch]  <= '0;
                            r_w[ch]  <= '0;
                            r_v[ch]  <= '0;
                            r_pw[ch] <= '0;
                        end
                        r_ovr       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (dsm.stop_in) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (dsm.sample_en) begin
                        if (w_frame_end) begin
                            for (int ch = 0; ch < NCH; ch++) begin
                                r_s[ch]  <= '0;
                                r_w[ch]  <= '0;
                                r_v[ch]  <= '0;
                                r_pw[ch] <= w_w_nx[ch];
                            end
                            r_cnt       <= '0;
                            r_have_prev <= 1'b1;
                            if (w_res_rdy) begin
                                r_result <= w_result;
                                r_valid  <= 1'b1;
                                if (r_valid && !dsm.result_ack_in) r_ovr <= 1'b1;
                                if (!r_cont) begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end
                        end else begin
                            for (int ch = 0; ch < NCH; ch++) begin
                                r_s[ch] <= w_s_nx[ch];
                                r_w[ch] <= w_w_nx[ch];
                                r_v[ch] <= w_v_nx[ch];
                            end
                            r_cnt <= r_cnt + OSR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign dsm.result_out              = r_result;
    assign dsm.result_valid_out        = r_valid;
    assign dsm.busy_out                = r_busy;
    assign dsm.conversion_finished_out = r_done;
    assign dsm.overrun_out             = r_ovr;
endmodule
